// File: rtl/proc_datapath.sv
// Datapath for the 9-bit simple processor: IR, R0-R7, A, G, step counter and
// a one-hot shared bus. IRLINE/COUNTERLINE feed back to the control unit.

module proc_datapath_reg #(
   parameter int WIDTH = 9
) (
   input  logic             CLOCK,
   input  logic             RESETN,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge CLOCK or negedge RESETN) begin
      if (!RESETN)  q <= '0;
      else if (en)  q <= d;
   end

endmodule

module proc_datapath #(
   parameter int WIDTH = 9
) (
   input  logic             CLOCK,
   input  logic             RESETN,
   input  logic [WIDTH-1:0] DIN,
   input  logic [9:0]       MUXLINE,
   input  logic [9:0]       REGSELECTORS,
   input  logic             ADDSUB,
   input  logic             IREN,
   input  logic             COUNTERCLR,
   output logic [8:0]       IRLINE,
   output logic [1:0]       COUNTERLINE,
   output logic [WIDTH-1:0] BUS,
   output logic             MUXERR
);

   localparam int NUM_REGS = 8;

   logic [NUM_REGS-1:0][WIDTH-1:0] rf;
   logic [WIDTH-1:0]               a_q, g_q, alu, bus_or;
   logic                           mux_legal;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_rf
         proc_datapath_reg #(.WIDTH(WIDTH)) u_reg (
            .CLOCK  (CLOCK),
            .RESETN (RESETN),
            .en     (REGSELECTORS[gi]),
            .d      (BUS),
            .q      (rf[gi])
         );
      end
   endgenerate

   proc_datapath_reg #(.WIDTH(WIDTH)) u_a (
      .CLOCK  (CLOCK),
      .RESETN (RESETN),
      .en     (REGSELECTORS[8]),
      .d      (BUS),
      .q      (a_q)
   );

   // G sees the pre-edge A, so a same-cycle A load does not affect the result.
   assign alu = ADDSUB ? (a_q - BUS) : (a_q + BUS);

   proc_datapath_reg #(.WIDTH(WIDTH)) u_g (
      .CLOCK  (CLOCK),
      .RESETN (RESETN),
      .en     (REGSELECTORS[9]),
      .d      (alu),
      .q      (g_q)
   );

   // Exactly one select bit set; anything else drives zero onto the bus.
   assign mux_legal = (MUXLINE != 10'd0) && ((MUXLINE & (MUXLINE - 10'd1)) == 10'd0);

   always_comb begin
      bus_or = '0;
      for (int i = 0; i < NUM_REGS; i++)
         if (MUXLINE[i]) bus_or = bus_or | rf[i];
      if (MUXLINE[8]) bus_or = bus_or | g_q;
      if (MUXLINE[9]) bus_or = bus_or | DIN;
   end

   assign BUS = mux_legal ? bus_or : '0;

   always_ff @(posedge CLOCK or negedge RESETN) begin
      if (!RESETN) begin
         IRLINE      <= '0;
         COUNTERLINE <= '0;
         MUXERR      <= 1'b0;
      end else begin
         if (IREN) IRLINE <= DIN[8:0];
         COUNTERLINE <= COUNTERCLR ? 2'd0 : COUNTERLINE + 2'd1;
         if (!mux_legal) MUXERR <= 1'b1;
      end
   end

endmodule

// File: tb/tb_proc_datapath.sv
// Randomised + directed bench for proc_datapath against an array-based
// behavioural model of the register machine.

module tb_proc_datapath;

   logic       CLOCK = 1'b0;
   logic       RESETN;
   logic [8:0] DIN;
   logic [9:0] MUXLINE, REGSELECTORS;
   logic       ADDSUB, IREN, COUNTERCLR;
   logic [8:0] IRLINE;
   logic [1:0] COUNTERLINE;
   logic [8:0] BUS;
   logic       MUXERR;

   proc_datapath #(.WIDTH(9)) dut (
      .CLOCK(CLOCK), .RESETN(RESETN), .DIN(DIN), .MUXLINE(MUXLINE),
      .REGSELECTORS(REGSELECTORS), .ADDSUB(ADDSUB), .IREN(IREN),
      .COUNTERCLR(COUNTERCLR), .IRLINE(IRLINE), .COUNTERLINE(COUNTERLINE),
      .BUS(BUS), .MUXERR(MUXERR)
   );

   always #5 CLOCK = ~CLOCK;

   int n_tests = 0;
   int n_fail  = 0;

   // reference machine state
   logic [8:0] mr [8];
   logic [8:0] ma, mg, mir;
   int         mcnt;
   bit         merr;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [8:0] model_bus();
      if ($countones(MUXLINE) != 1) return 9'd0;
      for (int i = 0; i < 8; i++) if (MUXLINE[i]) return mr[i];
      if (MUXLINE[8]) return mg;
      return DIN;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 8; i++) mr[i] = 9'd0;
      ma = 9'd0; mg = 9'd0; mir = 9'd0; mcnt = 0; merr = 1'b0;
   endfunction

   task automatic drive(input logic [9:0] mux, input logic [9:0] sel, input logic sub,
                        input logic ir, input logic clr, input logic [8:0] d);
      MUXLINE = mux; REGSELECTORS = sel; ADDSUB = sub; IREN = ir; COUNTERCLR = clr; DIN = d;
   endtask

   // One clock: check bus, apply the edge to the model, check registered outputs.
   task automatic step();
      logic [8:0] eb;
      #1;
      eb = model_bus();
      chk("bus", BUS, eb);
      @(posedge CLOCK);
      if (REGSELECTORS[9]) mg = ADDSUB ? ma - eb : ma + eb;
      if (REGSELECTORS[8]) ma = eb;
      for (int i = 0; i < 8; i++) if (REGSELECTORS[i]) mr[i] = eb;
      if (IREN) mir = DIN;
      mcnt = COUNTERCLR ? 0 : (mcnt + 1) % 4;
      if ($countones(MUXLINE) != 1) merr = 1'b1;
      #1;
      chk("irline", IRLINE, mir);
      chk("counter", COUNTERLINE, mcnt);
      chk("muxerr", MUXERR, merr);
   endtask

   task automatic reset_pulse();
      RESETN = 1'b0;
      #2;
      model_reset();
      chk("rst_ir", IRLINE, 0);
      chk("rst_cnt", COUNTERLINE, 0);
      chk("rst_err", MUXERR, 0);
      RESETN = 1'b1;
   endtask

   initial begin
      model_reset();
      RESETN = 1'b0;
      drive(10'h001, 10'h000, 1'b0, 1'b0, 1'b0, 9'h000);

      // reset held with random inputs toggling
      for (int k = 0; k < 6; k++) begin
         drive(10'($urandom), 10'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 9'($urandom));
         #1;
         chk("rst_bus", BUS, model_bus());
         chk("rst_ir", IRLINE, 0);
         chk("rst_cnt", COUNTERLINE, 0);
         chk("rst_err", MUXERR, 0);
         @(posedge CLOCK); #1;
      end
      drive(10'h001, 10'h000, 1'b0, 1'b0, 1'b0, 9'h000);
      RESETN = 1'b1;
      for (int k = 0; k < 5; k++) begin
         chk("cnt_seq", COUNTERLINE, k % 4);
         step();
      end

      // mvi R3, 0x05A
      drive(10'h200, 10'h008, 1'b0, 1'b0, 1'b0, 9'h05A); step();
      drive(10'h008, 10'h000, 1'b0, 1'b0, 1'b0, 9'h000); #1;
      chk("mvi_bus", BUS, 9'h05A); step();

      // add with wrap: 0x1FF + 0x002 = 0x001
      drive(10'h200, 10'h001, 1'b0, 1'b0, 1'b0, 9'h1FF); step();
      drive(10'h200, 10'h002, 1'b0, 1'b0, 1'b0, 9'h002); step();
      drive(10'h001, 10'h100, 1'b0, 1'b0, 1'b0, 9'h000); step();
      drive(10'h002, 10'h200, 1'b0, 1'b0, 1'b0, 9'h000); step();
      drive(10'h100, 10'h000, 1'b0, 1'b0, 1'b0, 9'h000); #1;
      chk("add_wrap", BUS, 9'h001); step();

      // sub with simultaneous A load: G = 3 - 5, A becomes 5
      drive(10'h200, 10'h100, 1'b0, 1'b0, 1'b0, 9'h003); step();
      drive(10'h200, 10'h004, 1'b0, 1'b0, 1'b0, 9'h005); step();
      drive(10'h004, 10'h300, 1'b1, 1'b0, 1'b0, 9'h000); step();
      drive(10'h100, 10'h000, 1'b0, 1'b0, 1'b0, 9'h000); #1;
      chk("sub_g", BUS, 9'h1FE); step();
      drive(10'h080, 10'h200, 1'b0, 1'b0, 1'b0, 9'h000); step(); // G = A + R7(0)
      drive(10'h100, 10'h000, 1'b0, 1'b0, 1'b0, 9'h000); #1;
      chk("sub_a", BUS, 9'h005); step();

      // IR load and counter clear at count 2
      drive(10'h001, 10'h000, 1'b0, 1'b1, 1'b0, 9'b001_010_011); #1;
      chk("ir_before", IRLINE, mir); step();
      chk("ir_load", IRLINE, 9'h053);
      drive(10'h001, 10'h000, 1'b0, 1'b0, 1'b0, 9'h000);
      for (int k = 0; k < 4 && mcnt != 2; k++) step();
      chk("cnt_at2", COUNTERLINE, 2);
      COUNTERCLR = 1'b1; step();
      chk("cnt_clr", COUNTERLINE, 0);
      COUNTERCLR = 1'b0; step();
      chk("cnt_r1", COUNTERLINE, 1); step();
      chk("cnt_r2", COUNTERLINE, 2);

      // illegal mux: zero bus, sticky error until reset
      drive(10'h003, 10'h000, 1'b0, 1'b0, 1'b0, 9'h1AB); #1;
      chk("illegal_bus", BUS, 0); step();
      chk("muxerr_set", MUXERR, 1);
      drive(10'h000, 10'h000, 1'b0, 1'b0, 1'b0, 9'h000); step();
      for (int k = 0; k < 3; k++) begin
         drive(10'h001 << k, 10'h000, 1'b0, 1'b0, 1'b0, 9'h000); step();
      end
      chk("muxerr_sticky", MUXERR, 1);
      reset_pulse();
      drive(10'h008, 10'h000, 1'b0, 1'b0, 1'b0, 9'h000); #1;
      chk("rst_clears_r3", BUS, 0);
      @(posedge CLOCK); #1;
      mcnt = 1;
      chk("cnt_after_rst", COUNTERLINE, 1);

      // random control words against the model
      for (int k = 0; k < 400; k++) begin
         logic [9:0] mux;
         if ($urandom_range(0, 11) == 0) mux = 10'($urandom);
         else                             mux = 10'd1 << $urandom_range(0, 9);
         drive(mux, 10'($urandom) & 10'($urandom), 1'($urandom), 1'($urandom),
               ($urandom_range(0, 3) == 0), 9'($urandom));
         step();
         if (k % 60 == 59) reset_pulse();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
